// File: rtl/hazard_scoreboard_pkg.sv
// Shared CPU defines: latency classes and pipeline control bundle
// used by the hazard scoreboard and ID decode.
package hazard_scoreboard_pkg;

  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_MFC0 = 1;
  localparam int LAT_MUL  = 3;

  localparam int NREG = 32;

  typedef struct packed {
    logic pc_wr;
    logic id_wr;
    logic exe_flush;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_RUN = '{
    pc_wr: 1'b1, id_wr: 1'b1, exe_flush: 1'b0
  };
  localparam pipe_ctl_t CTL_HOLD = '{
    pc_wr: 1'b0, id_wr: 1'b0, exe_flush: 1'b0
  };
  localparam pipe_ctl_t CTL_STALL = '{
    pc_wr: 1'b0, id_wr: 1'b0, exe_flush: 1'b1
  };

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One register's producer countdown: clear, hold,
// issue-load (never shortening a pending result) or decrement.
module sb_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr_i,
  input  logic             hold_i,
  input  logic             issue_i,
  input  logic [CNT_W-1:0] lat_i,
  output logic             busy_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] dec;

  assign dec = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);

  always_comb begin
    cnt_d = dec;
    if (clr_i) begin
      cnt_d = '0;
    end else if (hold_i) begin
      cnt_d = cnt_q;
    end else if (issue_i) begin
      cnt_d = (lat_i > dec) ? lat_i : dec;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW/WAW hazard scoreboard: per-register countdowns gate ID
// issue and stall the front end for exactly the producer latency.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int MAX_LAT = 3,
  localparam int CNT_W  = $clog2(MAX_LAT + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ID_Valid,
  input  logic [NUM_SRC*5-1:0] ID_Src,
  input  logic [NUM_SRC-1:0]   ID_SrcRead,
  input  logic [4:0]           ID_Dst,
  input  logic                 ID_DstWr,
  input  logic [CNT_W-1:0]     ID_Latency,
  input  logic                 Pipe_Hold,
  input  logic                 Flush,
  output logic                 PC_Wr,
  output logic                 ID_Wr,
  output logic                 EXE_Flush,
  output logic [31:0]          Stall_Cnt,
  output logic [31:0]          Busy_Mask
);

  logic [NREG-1:0]    busy;
  logic [NUM_SRC-1:0] src_haz;
  logic [CNT_W-1:0]   lat_sat;
  logic               hazard;
  logic               stall;
  logic               issue;
  logic [31:0]        stall_cnt_q;
  logic [31:0]        stall_cnt_d;
  pipe_ctl_t          ctl;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [4:0] src;
    assign src = ID_Src[5*k +: 5];
    assign src_haz[k] = ID_SrcRead[k] && (src != 5'd0) && busy[src];
  end

  assign hazard = ID_Valid && (|src_haz);
  assign stall  = hazard && !Pipe_Hold && !Flush;
  assign issue  = ID_Valid && ID_DstWr && (ID_Dst != 5'd0)
               && !hazard && !Pipe_Hold && !Flush;

  assign lat_sat = (ID_Latency > CNT_W'(MAX_LAT))
                 ? CNT_W'(MAX_LAT) : ID_Latency;

  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    sb_entry #(
      .CNT_W (CNT_W)
    ) u_ent (
      .clk     (clk),
      .resetn  (resetn),
      .clr_i   (Flush),
      .hold_i  (Pipe_Hold),
      .issue_i (issue && (ID_Dst == 5'(r))),
      .lat_i   (lat_sat),
      .busy_o  (busy[r])
    );
  end

  always_comb begin
    ctl = CTL_RUN;
    unique case (1'b1)
      Flush:               ctl = CTL_RUN;
      !Flush && Pipe_Hold: ctl = CTL_HOLD;
      stall:               ctl = CTL_STALL;
      default:             ctl = CTL_RUN;
    endcase
  end

  assign PC_Wr     = ctl.pc_wr;
  assign ID_Wr     = ctl.id_wr;
  assign EXE_Flush = ctl.exe_flush;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_Cnt = stall_cnt_q;
  assign Busy_Mask = busy;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, number of ID source-register ports (2..3).
REQ-002 SHALL have parameter MAX_LAT, default 3, largest producer latency tracked, in stall cycles (1..7).
REQ-003 SHALL have derived localparam CNT_W = clog2(MAX_LAT+1), countdown width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; the ports are listed first below.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 resetn  input  1  asynchronous active-low reset.
REQ-007 ID_Valid  input  1  valid instruction in ID.
REQ-008 ID_Src  input  NUM_SRC*5  packed source register numbers; port k occupies bits [5k+4:5k].
REQ-009 ID_SrcRead  input  NUM_SRC  bit k=1: source k is actually read.
REQ-010 ID_Dst  input  5  destination register.
REQ-011 ID_DstWr  input  1  instruction writes ID_Dst.
REQ-012 ID_Latency  input  CNT_W  stall cycles needed by an immediately following consumer (ALU 0, load/MFC0 1, multi-cycle up to MAX_LAT).
REQ-013 Pipe_Hold  input  1  whole pipeline frozen (cache miss etc.).
REQ-014 Flush  input  1  pipeline flush (exception/eret).
REQ-015 PC_Wr  output  1  PC may update.
REQ-016 ID_Wr  output  1  ID/EXE stage register may load.
REQ-017 EXE_Flush  output  1  insert bubble into EXE.
REQ-018 Stall_Cnt  output  32  saturating count of hazard-stall cycles.
REQ-019 Busy_Mask  output  32  bit r=1: register r has nonzero countdown.

Function
REQ-020 SHALL hold one CNT_W countdown per register 1..31; register 0 is never tracked, and its Busy_Mask bit SHALL be 0.
REQ-021 Hazard SHALL be asserted combinationally when: ID_Valid=1, some k has ID_SrcRead[k]=1, ID_Src[k]!=0, and the countdown for ID_Src[k] is >0.
REQ-022 When Hazard=1 and Pipe_Hold=0 and Flush=0, outputs SHALL be PC_Wr=0, ID_Wr=0, EXE_Flush=1.
REQ-023 When Pipe_Hold=1, outputs SHALL be PC_Wr=0, ID_Wr=0, EXE_Flush=0, and all countdowns SHALL hold their values.
REQ-024 Otherwise outputs SHALL be PC_Wr=1, ID_Wr=1, EXE_Flush=0.
REQ-025 Issue SHALL occur when ID_Valid=1, ID_DstWr=1, ID_Dst!=0, Hazard=0, Pipe_Hold=0 and Flush=0.
REQ-026 On issue, the countdown for ID_Dst SHALL load max(current-1 saturated at 0, min(ID_Latency, MAX_LAT)) at the next edge.
REQ-027 The WAW rule is that a shorter new latency never shortens a pending longer one.
REQ-028 Every non-issued countdown SHALL decrement by 1 per cycle, saturating at 0, unless Pipe_Hold=1.
REQ-029 Issue to register r and decrement of r in the same cycle SHALL resolve per REQ-026; no other entry is affected.
REQ-030 Flush=1 SHALL clear all countdowns to 0 at the next edge, suppress issue, and take priority over Pipe_Hold and Hazard.
REQ-031 During Flush=1, outputs SHALL be PC_Wr=1, ID_Wr=1, EXE_Flush=0.
REQ-032 Latency SHALL be exact: a producer with ID_Latency=L followed back-to-back by a dependent produces exactly L stall cycles.
REQ-033 ID_Latency=0 SHALL never stall, because forwarding covers it.
REQ-034 Stall_Cnt SHALL increment by 1 on each cycle where REQ-022 applies, saturating at 32'hFFFF_FFFF.
REQ-035 Busy_Mask and Stall_Cnt SHALL be driven directly from registered state.

Reset
REQ-036 resetn=0 SHALL asynchronously clear all countdowns and Stall_Cnt to 0.
REQ-037 During and after reset, outputs SHALL therefore be PC_Wr=1, ID_Wr=1, EXE_Flush=0, Busy_Mask=0, Stall_Cnt=0.
REQ-038 Reset asserted mid-stall SHALL release the stall immediately, without waiting for a clock.

Structure
REQ-039 The shared CPU defines package SHALL hold the latency-class constants LAT_ALU=0, LAT_LOAD=1, LAT_MFC0=1 and LAT_MUL; ID decode SHALL drive ID_Latency from them.
REQ-040 One sub-module SHALL be used, sb_entry: a single countdown with issue-load/decrement/hold/clear, instantiated 31 times via generate.
REQ-041 The source-compare logic SHALL be a generate loop over NUM_SRC.

Verification
REQ-042 Load to $5 (L=1), then next instruction reads $5 as rs -> one cycle with PC_Wr=0, ID_Wr=0, EXE_Flush=1; Stall_Cnt=1; no stall on the following cycle.
REQ-043 L=3 writer of $8, then rt-reader of $8 -> exactly 3 stall cycles; Busy_Mask[8] falls on the cycle the stall ends.
REQ-044 L=3 write $9, then immediately an L=0 write $9 issued after an unrelated instruction -> countdown not shortened; a reader of $9 still stalls for the remaining cycles.
REQ-045 Pipe_Hold=1 for 4 cycles during an L=2 countdown -> countdown frozen, EXE_Flush=0, Stall_Cnt unchanged; stall resumes after release with the remaining count.
REQ-046 Flush=1 while Busy_Mask=32'h0000_0120 -> next cycle Busy_Mask=0, no stall on a reader of $5/$8; reader of $0 with L=3 write to $0 -> never stalls.
REQ-047 Assert resetn=0 mid-stall -> PC_Wr=1 and Stall_Cnt=0 before the next clk edge.
